// File: rtl/compare_debouncer.sv
// Debounces comparator lt/eq/gt flags into an ABOVE/BELOW level with edge pulses,
// wrapping rise/fall event counters and a sticky illegal-flag error.
module compare_debouncer #(
  parameter int DEBOUNCE  = 4,
  parameter int CNT_WIDTH = 4,
  parameter int EVT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 lt,
  input  logic                 eq,
  input  logic                 gt,
  input  logic                 clear,
  output logic                 above,
  output logic                 below,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] run_len,
  output logic [EVT_WIDTH-1:0] rise_count,
  output logic [EVT_WIDTH-1:0] fall_count,
  output logic                 err
);

  typedef enum logic [1:0] {ST_UNKNOWN, ST_ABOVE, ST_BELOW} state_e;

  localparam logic [CNT_WIDTH-1:0] DEB = CNT_WIDTH'(DEBOUNCE);

  state_e                 state_q, state_d;
  logic                   cand_gt_q, cand_gt_d;
  logic [CNT_WIDTH-1:0]   run_q, run_d, run_try;
  logic                   rise_evt, fall_evt, legal;
  logic                   rise_pulse_q, fall_pulse_q, err_q;
  logic [EVT_WIDTH-1:0]   rise_cnt_q, fall_cnt_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v >= DEB) ? DEB : v + 1'b1;
  endfunction

  assign legal = ({lt, eq, gt} == 3'b100) || ({lt, eq, gt} == 3'b010) ||
                 ({lt, eq, gt} == 3'b001);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_UNKNOWN;
      cand_gt_q    <= 1'b0;
      run_q        <= '0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      rise_cnt_q   <= '0;
      fall_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_gt_q    <= cand_gt_d;
      run_q        <= run_d;
      rise_pulse_q <= rise_evt;
      fall_pulse_q <= fall_evt;
      // clear beats a same-cycle event for the counters; pulse/state are unaffected
      if (clear) begin
        rise_cnt_q <= '0;
        fall_cnt_q <= '0;
        err_q      <= 1'b0;
      end else begin
        if (rise_evt) rise_cnt_q <= rise_cnt_q + 1'b1;
        if (fall_evt) fall_cnt_q <= fall_cnt_q + 1'b1;
        if (in_valid && !legal) err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_gt_d = cand_gt_q;
    run_d     = run_q;
    run_try   = sat_inc(run_q);
    rise_evt  = 1'b0;
    fall_evt  = 1'b0;
    if (in_valid && legal) begin
      if (eq) begin
        run_d = '0;
      end else begin
        case (state_q)
          ST_UNKNOWN: begin
            // a flip of candidate direction restarts the run at this sample
            if (run_q == '0 || cand_gt_q != gt) run_try = CNT_WIDTH'(1);
            cand_gt_d = gt;
            if (run_try == DEB) begin
              state_d = gt ? ST_ABOVE : ST_BELOW;
              run_d   = '0;
            end else begin
              run_d = run_try;
            end
          end
          ST_ABOVE: begin
            if (!lt) begin
              run_d = '0;
            end else if (run_try == DEB) begin
              state_d  = ST_BELOW;
              fall_evt = 1'b1;
              run_d    = '0;
            end else begin
              run_d = run_try;
            end
          end
          ST_BELOW: begin
            if (!gt) begin
              run_d = '0;
            end else if (run_try == DEB) begin
              state_d  = ST_ABOVE;
              rise_evt = 1'b1;
              run_d    = '0;
            end else begin
              run_d = run_try;
            end
          end
          default: begin
            state_d = ST_UNKNOWN;
            run_d   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    above      = (state_q == ST_ABOVE);
    below      = (state_q == ST_BELOW);
    rise_pulse = rise_pulse_q;
    fall_pulse = fall_pulse_q;
    run_len    = run_q;
    rise_count = rise_cnt_q;
    fall_count = fall_cnt_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_compare_debouncer.sv
// Scoreboard bench for compare_debouncer: the driver queues hand-computed
// expectations per sample, a monitor pops and compares after each clock edge.
module tb_compare_debouncer;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1, in_valid = 1'b0, lt = 1'b0, eq = 1'b0, gt = 1'b0, clear = 1'b0;
  logic          above, below, rise_pulse, fall_pulse, err;
  logic [3:0]    run_len;
  logic [EW-1:0] rise_count, fall_count;

  always #5 clk = ~clk;

  compare_debouncer #(.DEBOUNCE(4), .CNT_WIDTH(4), .EVT_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .lt(lt), .eq(eq), .gt(gt),
    .clear(clear), .above(above), .below(below), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .run_len(run_len), .rise_count(rise_count),
    .fall_count(fall_count), .err(err)
  );

  typedef struct {
    int            id;
    logic          a, b, rp, fp, er;
    logic [3:0]    run;
    logic [EW-1:0] rc, fc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   checks = 0;
  int   passed = 0;
  int   vec_n  = 0;

  task automatic v(input logic vl, l, e, g, c, r,
                   input logic ea, eb, erp, efp, input int erun, erc, efc, input logic eerr);
    exp_t x;
    @(posedge clk);
    #2;
    in_valid = vl; lt = l; eq = e; gt = g; clear = c; reset = r;
    x.id = vec_n; x.a = ea; x.b = eb; x.rp = erp; x.fp = efp; x.er = eerr;
    x.run = erun[3:0]; x.rc = erc[EW-1:0]; x.fc = efc[EW-1:0];
    vec_n++;
    q.push_back(x);
  endtask

  task automatic gt_s(input logic ea, eb, erp, efp, input int erun, erc, efc, input logic eerr);
    v(1, 0, 0, 1, 0, 0, ea, eb, erp, efp, erun, erc, efc, eerr);
  endtask
  task automatic lt_s(input logic ea, eb, erp, efp, input int erun, erc, efc, input logic eerr);
    v(1, 1, 0, 0, 0, 0, ea, eb, erp, efp, erun, erc, efc, eerr);
  endtask
  task automatic eq_s(input logic ea, eb, erp, efp, input int erun, erc, efc, input logic eerr);
    v(1, 0, 1, 0, 0, 0, ea, eb, erp, efp, erun, erc, efc, eerr);
  endtask
  task automatic idle_s(input logic ea, eb, erp, efp, input int erun, erc, efc, input logic eerr);
    v(0, 0, 0, 0, 0, 0, ea, eb, erp, efp, erun, erc, efc, eerr);
  endtask

  // Monitor: outputs are settled 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m = q.pop_front();
      checks++;
      if (above === m.a && below === m.b && rise_pulse === m.rp && fall_pulse === m.fp &&
          run_len === m.run && rise_count === m.rc && fall_count === m.fc && err === m.er) begin
        passed++;
      end else begin
        $display("FAIL vec%0d: got above=%b below=%b rise=%b fall=%b run=%0d rc=%0d fc=%0d err=%b; want %b %b %b %b %0d %0d %0d %b",
                 m.id, above, below, rise_pulse, fall_pulse, run_len, rise_count, fall_count, err,
                 m.a, m.b, m.rp, m.fp, m.run, m.rc, m.fc, m.er);
      end
    end
  end

  initial begin
    // reset state
    v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // 4 gt from UNKNOWN -> ABOVE with no pulse and no count
    for (int k = 1; k <= 3; k++) gt_s(0, 0, 0, 0, k, 0, 0, 0);
    gt_s(1, 0, 0, 0, 0, 0, 0, 0);
    idle_s(1, 0, 0, 0, 0, 0, 0, 0);

    // ABOVE: lt,lt,lt,eq restarts, then 4 lt -> fall
    for (int k = 1; k <= 3; k++) lt_s(1, 0, 0, 0, k, 0, 0, 0);
    eq_s(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) lt_s(1, 0, 0, 0, k, 0, 0, 0);
    lt_s(0, 1, 0, 1, 0, 0, 1, 0);
    idle_s(0, 1, 0, 0, 0, 0, 1, 0);

    // BELOW: gt,gt, 5 idle gaps, gt,gt -> rise
    gt_s(0, 1, 0, 0, 1, 0, 1, 0);
    gt_s(0, 1, 0, 0, 2, 0, 1, 0);
    for (int k = 0; k < 5; k++) idle_s(0, 1, 0, 0, 2, 0, 1, 0);
    gt_s(0, 1, 0, 0, 3, 0, 1, 0);
    gt_s(1, 0, 1, 0, 0, 1, 1, 0);
    idle_s(1, 0, 0, 0, 0, 1, 1, 0);

    // illegal flags: sticky err, run kept; clear zeroes err and counts
    lt_s(1, 0, 0, 0, 1, 1, 1, 0);
    v(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1);
    idle_s(1, 0, 0, 0, 1, 1, 1, 1);
    lt_s(1, 0, 0, 0, 2, 1, 1, 1);
    v(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2, 0, 0, 0);
    eq_s(1, 0, 0, 0, 0, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    v(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // 16 fall/rise cycles: counters wrap back to 0
    for (int i = 0; i < 16; i++) begin
      for (int k = 1; k <= 3; k++) lt_s(1, 0, 0, 0, k, i, i, 0);
      lt_s(0, 1, 0, 1, 0, i, i + 1, 0);
      for (int k = 1; k <= 3; k++) gt_s(0, 1, 0, 0, k, i, i + 1, 0);
      gt_s(1, 0, 1, 0, 0, i + 1, i + 1, 0);
    end

    // clear in the same cycle as a fall: count 0, pulse still fires
    for (int k = 1; k <= 3; k++) lt_s(1, 0, 0, 0, k, 0, 0, 0);
    v(1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    idle_s(0, 1, 0, 0, 0, 0, 0, 0);

    // reset mid-run (run_len=3) returns to UNKNOWN
    for (int k = 1; k <= 3; k++) gt_s(0, 1, 0, 0, k, 0, 0, 0);
    v(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // UNKNOWN: direction flip restarts run, eq clears it, lt run -> BELOW silently
    gt_s(0, 0, 0, 0, 1, 0, 0, 0);
    lt_s(0, 0, 0, 0, 1, 0, 0, 0);
    eq_s(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) lt_s(0, 0, 0, 0, k, 0, 0, 0);
    lt_s(0, 1, 0, 0, 0, 0, 0, 0);
    idle_s(0, 1, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expectations, want 0", q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
